// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
// Shared types and helpers for the 5-stage pipeline hazard controller.
//   fwd_sel_t : EX operand mux select (regfile / MEM aluRes / WB result)
//   hstate_t  : halt sequencer state
//   slot_t    : shadow copy of one in-flight instruction's register usage
// Slot address fields are SLOT_ADDR_W wide; the controller zero-extends its
// REG_ADDR_W addresses into them, so REG_ADDR_W must not exceed SLOT_ADDR_W.
// ---------------------------------------------------------------------------
package hazard_pkg;

    localparam int SLOT_ADDR_W = 8;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        DRAIN  = 2'b01,
        HALTED = 2'b10
    } hstate_t;

    typedef struct packed {
        logic                   valid;
        logic [SLOT_ADDR_W-1:0] rd;
        logic                   reg_write;
        logic                   is_load;
        logic [SLOT_ADDR_W-1:0] rs1;
        logic [SLOT_ADDR_W-1:0] rs2;
        logic                   use1;
        logic                   use2;
    } slot_t;

    // True when slot s is a live producer of register src that the
    // consumer actually reads.
    function automatic logic slot_writes(input slot_t                  s,
                                         input logic [SLOT_ADDR_W-1:0] src,
                                         input logic                   use_src);
        return s.valid & s.reg_write & (s.rd == src) & use_src;
    endfunction

    // Operand source for one EX-stage read; the younger MEM result wins.
    function automatic fwd_sel_t fwd_pick(input slot_t                  mem_s,
                                          input slot_t                  wb_s,
                                          input logic [SLOT_ADDR_W-1:0] src,
                                          input logic                   use_src);
        if (slot_writes(mem_s, src, use_src)) begin
            return FWD_MEM;
        end else if (slot_writes(wb_s, src, use_src)) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_slot_pipe.sv
// ---------------------------------------------------------------------------
// hazard_slot_pipe
// Three-deep shadow shift register (EX -> MEM -> WB) of instruction register
// usage. A new slot enters EX only on issue; otherwise a bubble enters.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (all slots invalid)
//   i_issue    : ID instruction issues into EX this cycle
//   i_id_slot  : slot built from the ID-stage instruction
//   o_ex/o_mem/o_wb : current contents of the EX, MEM and WB slots
// ---------------------------------------------------------------------------
module hazard_slot_pipe
    import hazard_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  i_issue,
    input  slot_t i_id_slot,
    output slot_t o_ex,
    output slot_t o_mem,
    output slot_t o_wb
);

    // [0]=EX, [1]=MEM, [2]=WB
    slot_t [2:0] r_stage;
    slot_t       w_ex_in;

    assign w_ex_in = i_issue ? i_id_slot : slot_t'('0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stage <= '0;
        end else begin
            r_stage <= {r_stage[1], r_stage[0], w_ex_in};
        end
    end

    assign o_ex  = r_stage[0];
    assign o_mem = r_stage[1];
    assign o_wb  = r_stage[2];

endmodule

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Pipeline control for the IF/ID/EX/MEM/WB core: RAW detection, optional EX
// forwarding, load-use stall, taken-branch flush, drained halt, and a
// saturating count of stalled cycles.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   id_valid .. id_halt      : decoded register usage of the ID instruction
//   ex_branch_taken          : EX resolves a taken branch/jump this cycle
//   stall_f, stall_d         : hold PC / hold IF/ID
//   flush_d, flush_e         : clear IF/ID / bubble into ID/EX
//   fwd_a, fwd_b             : EX operand selects (00 RF, 01 MEM, 10 WB)
//   halted                   : pipeline drained and stopped (registered)
//   stall_cycles             : saturating count of stall_d cycles (registered)
// ---------------------------------------------------------------------------
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W   = 4,
    parameter int FWD_EN       = 1,
    parameter int CNT_W        = 16,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_is_load,
    input  logic                  id_halt,
    input  logic                  ex_branch_taken,
    output logic                  stall_f,
    output logic                  stall_d,
    output logic                  flush_d,
    output logic                  flush_e,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic                  halted,
    output logic [CNT_W-1:0]      stall_cycles
);

    localparam int DCNT_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

    slot_t      w_id_slot;
    slot_t      w_ex;
    slot_t      w_mem;
    slot_t      w_wb;
    slot_t      w_slot_arr [3];
    logic [2:0] w_src_hit;
    logic       w_load_use;
    logic       w_data_stall;

    hstate_t             r_state;
    hstate_t             w_state_next;
    logic [DCNT_W-1:0]   r_dcnt;
    logic [DCNT_W-1:0]   w_dcnt_next;
    logic                r_halted;
    logic [CNT_W-1:0]    r_stall_cnt;

    logic                w_stall;
    logic                w_flush_d;
    logic                w_flush_e;
    logic                w_issue;
    fwd_sel_t            w_fwd_a;
    fwd_sel_t            w_fwd_b;

    // ID instruction as it would appear in the EX slot once issued.
    always_comb begin
        w_id_slot           = '0;
        w_id_slot.valid     = 1'b1;
        w_id_slot.rd        = SLOT_ADDR_W'(id_rd);
        w_id_slot.reg_write = id_reg_write;
        w_id_slot.is_load   = id_is_load;
        w_id_slot.rs1       = SLOT_ADDR_W'(id_rs1);
        w_id_slot.rs2       = SLOT_ADDR_W'(id_rs2);
        w_id_slot.use1      = id_use_rs1;
        w_id_slot.use2      = id_use_rs2;
    end

    hazard_slot_pipe u_slot_pipe (
        .clk       (clk),
        .rst       (rst),
        .i_issue   (w_issue),
        .i_id_slot (w_id_slot),
        .o_ex      (w_ex),
        .o_mem     (w_mem),
        .o_wb      (w_wb)
    );

    assign w_slot_arr[0] = w_ex;
    assign w_slot_arr[1] = w_mem;
    assign w_slot_arr[2] = w_wb;

    // Per-slot: does this slot produce a register the ID instruction reads?
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_hit
            assign w_src_hit[gi] =
                slot_writes(w_slot_arr[gi], w_id_slot.rs1, id_use_rs1) |
                slot_writes(w_slot_arr[gi], w_id_slot.rs2, id_use_rs2);
        end
    endgenerate

    assign w_load_use = w_src_hit[0] & w_ex.is_load;

    // Without forwarding the regfile is not write-through, so a producer
    // still in WB blocks the read just like one in EX or MEM.
    assign w_data_stall = id_valid & ((FWD_EN != 0) ? w_load_use : (|w_src_hit));

    // Control outputs and halt sequencer next state.
    always_comb begin
        w_stall      = 1'b0;
        w_flush_d    = 1'b0;
        w_flush_e    = 1'b0;
        w_issue      = 1'b0;
        w_state_next = r_state;
        w_dcnt_next  = r_dcnt;
        case (r_state)
            RUN: begin
                // A taken branch kills the ID instruction, so any stall it
                // would have caused is moot.
                if (ex_branch_taken) begin
                    w_flush_d = 1'b1;
                    w_flush_e = 1'b1;
                end else if (w_data_stall) begin
                    w_stall   = 1'b1;
                    w_flush_e = 1'b1;
                end
                w_issue = id_valid & ~w_stall & ~w_flush_e;
                if (w_issue && id_halt) begin
                    w_state_next = DRAIN;
                    w_dcnt_next  = DCNT_W'(DRAIN_CYCLES);
                end
            end
            DRAIN: begin
                w_stall   = 1'b1;
                w_flush_e = 1'b1;
                if ((r_dcnt == '0) || (r_dcnt == DCNT_W'(1))) begin
                    w_state_next = HALTED;
                end else begin
                    w_dcnt_next = r_dcnt - DCNT_W'(1);
                end
            end
            HALTED: begin
                w_stall   = 1'b1;
                w_flush_e = 1'b1;
            end
            default: begin
                w_state_next = RUN;
            end
        endcase
    end

    // Forwarding for the instruction currently in EX.
    always_comb begin
        w_fwd_a = FWD_RF;
        w_fwd_b = FWD_RF;
        if (FWD_EN != 0) begin
            w_fwd_a = fwd_pick(w_mem, w_wb, w_ex.rs1, w_ex.valid & w_ex.use1);
            w_fwd_b = fwd_pick(w_mem, w_wb, w_ex.rs2, w_ex.valid & w_ex.use2);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= RUN;
            r_dcnt      <= '0;
            r_halted    <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_state  <= w_state_next;
            r_dcnt   <= w_dcnt_next;
            r_halted <= (w_state_next == HALTED);
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    // Some slot fields only matter in particular stages or configurations.
    logic w_unused_bits;
    assign w_unused_bits = ^{w_ex, w_mem, w_wb};

    assign stall_f      = w_stall;
    assign stall_d      = w_stall;
    assign flush_d      = w_flush_d;
    assign flush_e      = w_flush_e;
    assign fwd_a        = w_fwd_a;
    assign fwd_b        = w_fwd_b;
    assign halted       = r_halted;
    assign stall_cycles = r_stall_cnt;

endmodule
